// File: rtl/bus_register_if.sv
// Bus-side signal bundle for one register on the shared CPU data bus.
// The controller holds the master modport; the register holds the slave modport.
interface bus_register_if #(
  parameter int WIDTH = 8
);
  logic             read_from_bus;
  logic             write_to_bus;
  logic [WIDTH-1:0] bus_in;
  logic [WIDTH-1:0] bus_out;
  logic [WIDTH-1:0] value;

  modport master (
    output read_from_bus,
    output write_to_bus,
    output bus_in,
    input  bus_out,
    input  value
  );

  modport slave (
    input  read_from_bus,
    input  write_to_bus,
    input  bus_in,
    output bus_out,
    output value
  );
endinterface

// File: rtl/bus_register.sv
// Parallel register on the shared data bus: loads the bus on command, always exposes its
// full contents on value, and drives a masked copy onto bus_out when enabled.
module bus_register #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] OUT_MASK = {WIDTH{1'b1}}
) (
  input  logic          clk,
  input  logic          rst,
  bus_register_if.slave bus
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (bus.read_from_bus) q_d = bus.bus_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q_q <= '0;
    else      q_q <= q_d;
  end

  // Disabled output is all zeros so the external OR-combine of bus drivers stays safe.
  assign bus.bus_out = bus.write_to_bus ? (q_q & OUT_MASK) : '0;
  assign bus.value   = q_q;

endmodule

// File: tb/tb_bus_register.sv
// Bench for bus_register: an instruction-register instance (mask 0F) and a general
// register instance (mask FF) share stimulus and are compared against a reference model.
module tb_bus_register;
  localparam int         W      = 8;
  localparam logic [7:0] MASK_A = 8'h0F;
  localparam logic [7:0] MASK_B = 8'hFF;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rd  = 1'b0;
  logic       wr  = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] exp_q = 8'h00;
  int         pass_cnt = 0;
  int         total_cnt = 0;

  always #5 clk = ~clk;

  bus_register_if #(.WIDTH(W)) ifa ();
  bus_register_if #(.WIDTH(W)) ifb ();

  assign ifa.read_from_bus = rd;
  assign ifa.write_to_bus  = wr;
  assign ifa.bus_in        = din;
  assign ifb.read_from_bus = rd;
  assign ifb.write_to_bus  = wr;
  assign ifb.bus_in        = din;

  bus_register #(.WIDTH(W), .OUT_MASK(MASK_A)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  bus_register #(.WIDTH(W), .OUT_MASK(MASK_B)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  // Reference model: register content changes only at a rising edge, and reset clears it.
  task automatic tick();
    logic [7:0] nxt;
    nxt = !rst ? 8'h00 : (rd ? din : exp_q);
    @(posedge clk);
    #1;
    exp_q = nxt;
  endtask

  function automatic logic [7:0] drive(input logic [7:0] q, input logic [7:0] m, input logic en);
    return en ? (q & m) : 8'h00;
  endfunction

  task automatic test_reset();
    rst = 1'b0; din = 8'hA5; rd = 1'b1; wr = 1'b1;
    exp_q = 8'h00;
    for (int i = 0; i < 4; i++) begin
      tick();
      total_cnt++; if (ifa.value !== 8'h00) $display("FAIL reset_value_a got %h want 00", ifa.value); else pass_cnt++;
      total_cnt++; if (ifb.value !== 8'h00) $display("FAIL reset_value_b got %h want 00", ifb.value); else pass_cnt++;
      total_cnt++; if (ifa.bus_out !== 8'h00) $display("FAIL reset_out_a got %h want 00", ifa.bus_out); else pass_cnt++;
      total_cnt++; if (ifb.bus_out !== 8'h00) $display("FAIL reset_out_b got %h want 00", ifb.bus_out); else pass_cnt++;
    end
    rd = 1'b0; wr = 1'b0;
    #2 rst = 1'b1;
  endtask

  task automatic test_load_hold();
    din = 8'h3C; rd = 1'b1; wr = 1'b0;
    tick();
    rd = 1'b0; din = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      total_cnt++; if (ifa.value !== 8'h3C) $display("FAIL hold_value_a[%0d] got %h want 3c", i, ifa.value); else pass_cnt++;
      total_cnt++; if (ifb.value !== 8'h3C) $display("FAIL hold_value_b[%0d] got %h want 3c", i, ifb.value); else pass_cnt++;
      total_cnt++; if (ifb.bus_out !== 8'h00) $display("FAIL hold_out_b[%0d] got %h want 00", i, ifb.bus_out); else pass_cnt++;
      tick();
    end
    total_cnt++; if (ifa.value !== 8'h3C) $display("FAIL hold_value_final got %h want 3c", ifa.value); else pass_cnt++;
  endtask

  task automatic test_masked_drive();
    din = 8'hE7; rd = 1'b1;
    tick();
    rd = 1'b0; wr = 1'b1;
    #1;
    total_cnt++; if (ifa.bus_out !== 8'h07) $display("FAIL masked_out got %h want 07", ifa.bus_out); else pass_cnt++;
    total_cnt++; if (ifa.value !== 8'hE7) $display("FAIL masked_value got %h want e7", ifa.value); else pass_cnt++;
    total_cnt++; if (ifb.bus_out !== 8'hE7) $display("FAIL masked_peer_out got %h want e7", ifb.bus_out); else pass_cnt++;
    wr = 1'b0;
    #1;
    total_cnt++; if (ifa.bus_out !== 8'h00) $display("FAIL masked_off got %h want 00", ifa.bus_out); else pass_cnt++;
    tick();
  endtask

  task automatic test_unmasked_drive();
    din = 8'h5A; rd = 1'b1;
    tick();
    rd = 1'b0; wr = 1'b1;
    #1;
    total_cnt++; if (ifb.bus_out !== 8'h5A) $display("FAIL unmasked_out got %h want 5a", ifb.bus_out); else pass_cnt++;
    total_cnt++; if (ifa.bus_out !== 8'h0A) $display("FAIL unmasked_peer_out got %h want 0a", ifa.bus_out); else pass_cnt++;
    wr = 1'b0;
    tick();
  endtask

  task automatic test_simultaneous();
    din = 8'h12; rd = 1'b1; wr = 1'b0;
    tick();
    din = 8'h34; rd = 1'b1; wr = 1'b1;
    #1;
    total_cnt++; if (ifa.bus_out !== 8'h02) $display("FAIL simul_pre_out got %h want 02", ifa.bus_out); else pass_cnt++;
    total_cnt++; if (ifa.value !== 8'h12) $display("FAIL simul_pre_value got %h want 12", ifa.value); else pass_cnt++;
    tick();
    rd = 1'b0;
    #1;
    total_cnt++; if (ifa.value !== 8'h34) $display("FAIL simul_post_value got %h want 34", ifa.value); else pass_cnt++;
    total_cnt++; if (ifa.bus_out !== 8'h04) $display("FAIL simul_post_out got %h want 04", ifa.bus_out); else pass_cnt++;
    wr = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    din = 8'hC3; rd = 1'b1; wr = 1'b1;
    tick();
    total_cnt++; if (ifb.value !== 8'hC3) $display("FAIL async_preload got %h want c3", ifb.value); else pass_cnt++;
    din = 8'h55;
    #2 rst = 1'b0;
    exp_q = 8'h00;
    #1;
    total_cnt++; if (ifb.value !== 8'h00) $display("FAIL async_value_noedge got %h want 00", ifb.value); else pass_cnt++;
    total_cnt++; if (ifb.bus_out !== 8'h00) $display("FAIL async_out_noedge got %h want 00", ifb.bus_out); else pass_cnt++;
    tick();
    total_cnt++; if (ifb.value !== 8'h00) $display("FAIL async_load_ignored got %h want 00", ifb.value); else pass_cnt++;
    rd = 1'b0; wr = 1'b0;
    #2 rst = 1'b1;
    tick();
    total_cnt++; if (ifa.value !== 8'h00) $display("FAIL async_after_release got %h want 00", ifa.value); else pass_cnt++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rd  = 1'($urandom_range(0, 1));
      wr  = 1'($urandom_range(0, 1));
      din = 8'($urandom);
      if ($urandom_range(0, 31) == 0) begin
        rst = 1'b0;
        exp_q = 8'h00;
      end else begin
        rst = 1'b1;
      end
      #1;
      total_cnt++; if (ifa.value !== exp_q) $display("FAIL rand_value_a[%0d] got %h want %h", i, ifa.value, exp_q); else pass_cnt++;
      total_cnt++; if (ifb.value !== exp_q) $display("FAIL rand_value_b[%0d] got %h want %h", i, ifb.value, exp_q); else pass_cnt++;
      total_cnt++; if (ifa.bus_out !== drive(exp_q, MASK_A, wr))
        $display("FAIL rand_out_a[%0d] got %h want %h", i, ifa.bus_out, drive(exp_q, MASK_A, wr)); else pass_cnt++;
      total_cnt++; if (ifb.bus_out !== drive(exp_q, MASK_B, wr))
        $display("FAIL rand_out_b[%0d] got %h want %h", i, ifb.bus_out, drive(exp_q, MASK_B, wr)); else pass_cnt++;
      tick();
    end
    rst = 1'b1; rd = 1'b0; wr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_hold();
    test_masked_drive();
    test_unmasked_drive();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/bus_register.md
# bus_register

Single-width parallel register attached to the shared 8-bit CPU data bus. It latches the bus when commanded and exposes its full contents on a dedicated `value` output for downstream decode and ALU logic. It drives a masked copy of its contents back onto the bus when enabled. With mask `8'h0F` it serves as the instruction register, placing only the operand/address nibble on the bus. With mask `8'hFF` it serves as a general A/B/output register.

## Interface
- `WIDTH`, default 8: register and bus width in bits.
- `OUT_MASK`, default `8'hFF` (`WIDTH` bits): bitwise mask applied to the contents before driving `bus_out`. The instruction-register instance uses `8'h0F`.

Ports:
- `clk`  input  1  single system clock; all state changes on its rising edge.
- `rst`  input  1  reset; asynchronous, active-low.
- `read_from_bus`  input  1  load enable; when high, capture `bus_in` at the next rising edge.
- `write_to_bus`  input  1  output enable; when high, drive masked contents onto `bus_out`.
- `bus_in`  input  `WIDTH`  current value of the shared bus.
- `bus_out`  output  `WIDTH`  this register's contribution to the bus; OR/mux-combined externally, no tri-states.
- `value`  output  `WIDTH`  full, unmasked register contents, always valid.

## Operation
- Internal storage: one `WIDTH`-bit register `q`; `value = q` continuously.
- Load: on a rising edge of `clk` with `rst` high and `read_from_bus = 1`, `q <= bus_in`.
- Hold: with `read_from_bus = 0`, `q` is unchanged.
- Bus drive is combinational: `bus_out = write_to_bus ? (q & OUT_MASK) : 0`.
  - When disabled, `bus_out` is all zeros so an external OR-combine is safe.
- The mask affects only `bus_out`; `value` always carries all `WIDTH` bits.
  - Example: the instruction register exposes the opcode nibble on `value[7:4]` and drives only `value[3:0]` to the bus.
- `read_from_bus` and `write_to_bus` both high is legal (a bus self-loop). `bus_out` shows the pre-edge `q`; `q` takes `bus_in` at the edge.
- X-safety: no latches; every output is defined in all states of the enables.

## Timing
- Reset: `rst` low forces `q = 0` immediately, independent of `clk`.
  - While reset is asserted: `value = 0`, and `bus_out = 0` regardless of `write_to_bus`.
- Reset release: leaving reset is synchronous-safe. The first load occurs at the first rising edge with `rst` high and `read_from_bus = 1`.
- Reset mid-operation: asserting `rst` during a load cycle discards the load; `q` stays 0 until a later edge.
- Load latency: 1 clock. `bus_in` is sampled at the rising edge and appears on `value` immediately after that edge.
- Drive latency: 0 clocks. `bus_out` follows `write_to_bus` and `q` combinationally within the same cycle.
- `bus_in` must be stable around the rising edge when `read_from_bus = 1`; standard setup/hold apply.
- No handshake, no back-pressure; enables are single-cycle levels from the controller.

## Test plan
- Reset: drive `rst = 0` with `bus_in = 8'hA5`, `read_from_bus = 1`, `write_to_bus = 1`, clock toggling -> `value = 8'h00`, `bus_out = 8'h00` throughout.
- Load and hold: release reset, `bus_in = 8'h3C`, pulse `read_from_bus` for one edge, then set `bus_in = 8'hFF` with the enable low for 3 edges -> `value = 8'h3C` from the edge after the pulse onward.
- Masked drive (`OUT_MASK = 8'h0F`): load `8'hE7`, set `write_to_bus = 1` -> `bus_out = 8'h07` in the same cycle, `value = 8'hE7`; set `write_to_bus = 0` -> `bus_out = 8'h00`.
- Unmasked drive (`OUT_MASK = 8'hFF`): load `8'h5A`, set `write_to_bus = 1` -> `bus_out = 8'h5A`.
- Simultaneous enables: with `q = 8'h12`, set `read_from_bus = 1`, `write_to_bus = 1`, `bus_in = 8'h34` -> `bus_out = 8'h02` before the edge (mask `8'h0F`); after the edge `value = 8'h34`, `bus_out = 8'h04`.
- Async reset mid-run: with `q = 8'hC3`, drop `rst` between clock edges -> `value = 8'h00` with no clock edge; a load requested in the same cycle is ignored.
